// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package load_store_unit_pkg;

  // Memory access width, encoded exactly as the instruction funct3 field.
  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  // Number of byte accesses for a width; illegal encodings never reach ACCESS.
  function automatic logic [2:0] width_to_bytes(input logic [2:0] width);
    case (width)
      MW_H, MW_HU: width_to_bytes = 3'd2;
      MW_W:        width_to_bytes = 3'd4;
      default:     width_to_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of assembled load data.
module lsu_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] ld_buf,
  input  logic [2:0]  width,
  input  logic        kill,
  output logic [31:0] rdata
);

  // Extend according to width; kill forces zero for stores, errors and non-DONE cycles.
  always_comb begin
    rdata = '0;
    if (!kill) begin
      case (width)
        MW_B:    rdata = {{24{ld_buf[7]}}, ld_buf[7:0]};
        MW_H:    rdata = {{16{ld_buf[15]}}, ld_buf[15:0]};
        MW_W:    rdata = ld_buf;
        MW_BU:   rdata = {24'd0, ld_buf[7:0]};
        MW_HU:   rdata = {16'd0, ld_buf[15:0]};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store engine between the control FSM and a byte-wide RAM.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | ready for a request; latch and check it on req_valid
//   ST_ACCESS | one byte per cycle, little-endian, byte_idx 0..N-1
//   ST_DONE   | single-cycle done pulse with err/rdata, then IDLE
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_width,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_t        state, state_nxt;
  logic [1:0]        byte_idx;
  logic              wr_q;
  logic [2:0]        width_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ld_buf;
  logic              err_q;

  logic              accept;
  logic              req_bad;
  logic              last_byte;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign last_byte = ({1'b0, byte_idx} == (width_to_bytes(width_q) - 3'd1));

  // Legality of the incoming request: bad encodings, unsigned stores, misalignment.
  always_comb begin
    req_bad = 1'b0;
    case (req_width)
      MW_B:        req_bad = 1'b0;
      MW_H:        req_bad = req_addr[0];
      MW_W:        req_bad = (req_addr[1:0] != 2'b00);
      MW_BU:       req_bad = req_write;
      MW_HU:       req_bad = req_write | req_addr[0];
      default:     req_bad = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = req_bad ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (last_byte) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, byte index and load byte assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      wr_q     <= 1'b0;
      width_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ld_buf   <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      byte_idx <= '0;
      wr_q     <= req_write;
      width_q  <= req_width;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      ld_buf   <= '0;
      err_q    <= req_bad;
    end else if (state == ST_ACCESS) begin
      if (!wr_q) ld_buf[{byte_idx, 3'b000} +: 8] <= mem_rdata;
      if (!last_byte) byte_idx <= byte_idx + 2'd1;
    end
  end

  // Outputs are decoded from registered state; mem_we follows the async reset.
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err       = done & err_q;
  assign mem_we    = (state == ST_ACCESS) & wr_q;
  assign mem_addr  = addr_q + ADDR_W'(byte_idx);
  assign mem_wdata = wdata_q[{byte_idx, 3'b000} +: 8];

  lsu_extend u_extend (
    .ld_buf (ld_buf),
    .width  (width_q),
    .kill   (!done | err_q | wr_q),
    .rdata  (rdata)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 256-byte RAM model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:255];
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [7:0]  pl_data;

  int n_cmp;
  int n_fail;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_width (req_width),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we)     ram[mem_addr[7:0]] <= mem_wdata;
    else if (pl_we) ram[pl_addr] <= pl_data;
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [2:0] wd, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_width = wd; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for done (bounded); cycles = 0 means no done within the budget.
  task automatic wait_done(output int cycles, output int we_cnt, output logic [31:0] rd, output logic e);
    cycles = 0; we_cnt = 0; rd = 'x; e = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (done) begin
        cycles = k; rd = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_in_reset: got %b want 0", mem_we); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if ({done, err, busy, mem_we} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {done, err, busy, mem_we}); end
    n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if (mem_addr !== 32'd0 || mem_wdata !== 8'd0) begin n_fail++; $display("FAIL reset_mem: got %h/%h want 0/0", mem_addr, mem_wdata); end
  endtask

  task automatic test_lw;
    poke(8'h80, 8'h58); poke(8'h81, 8'h00); poke(8'h82, 8'h00); poke(8'h83, 8'h00);
    issue(1'b0, 3'b010, 32'h80, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (mem_addr !== 32'h80 + k) begin n_fail++; $display("FAIL lw_addr%0d: got %h want %h", k, mem_addr, 32'h80 + k); end
      n_cmp++; if ({mem_we, busy, done} !== 3'b010) begin n_fail++; $display("FAIL lw_ctl%0d: got %b want 010", k, {mem_we, busy, done}); end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL lw_done: got %b want 1", done); end
    n_cmp++; if (rdata !== 32'h00000058) begin n_fail++; $display("FAIL lw_rdata: got %h want 00000058", rdata); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", err); end
    @(negedge clk);
    n_cmp++; if ({done, req_ready} !== 2'b01) begin n_fail++; $display("FAIL lw_after: got %b want 01", {done, req_ready}); end
  endtask

  task automatic test_lb_lbu_lh;
    int cyc, wec; logic [31:0] rd; logic e;
    poke(8'h80, 8'h85);
    issue(1'b0, 3'b000, 32'h80, 32'h0);
    wait_done(cyc, wec, rd, e);
    n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", cyc); end
    n_cmp++; if (rd !== 32'hFFFFFF85) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff85", rd); end
    issue(1'b0, 3'b100, 32'h80, 32'h0);
    wait_done(cyc, wec, rd, e);
    n_cmp++; if (rd !== 32'h00000085) begin n_fail++; $display("FAIL lbu_rdata: got %h want 00000085", rd); end
    poke(8'h7E, 8'h00); poke(8'h7F, 8'h80);
    issue(1'b0, 3'b001, 32'h7E, 32'h0);
    wait_done(cyc, wec, rd, e);
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL lh_latency: got %0d want 3", cyc); end
    n_cmp++; if (rd !== 32'hFFFF8000) begin n_fail++; $display("FAIL lh_rdata: got %h want ffff8000", rd); end
    issue(1'b0, 3'b101, 32'h7E, 32'h0);
    wait_done(cyc, wec, rd, e);
    n_cmp++; if (rd !== 32'h00008000) begin n_fail++; $display("FAIL lhu_rdata: got %h want 00008000", rd); end
  endtask

  task automatic test_sh;
    int cyc, wec; logic [31:0] rd; logic e;
    poke(8'h7A, 8'h00); poke(8'h7B, 8'h00); poke(8'h7C, 8'h5A);
    issue(1'b1, 3'b001, 32'h7A, 32'hABCD1234);
    wait_done(cyc, wec, rd, e);
    n_cmp++; if (wec !== 2) begin n_fail++; $display("FAIL sh_we_cycles: got %0d want 2", wec); end
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", cyc); end
    n_cmp++; if (rd !== 32'd0 || e !== 1'b0) begin n_fail++; $display("FAIL sh_result: got %h/%b want 0/0", rd, e); end
    n_cmp++; if ({ram[8'h7A], ram[8'h7B], ram[8'h7C]} !== 24'h34125A) begin n_fail++; $display("FAIL sh_ram: got %h want 34125a", {ram[8'h7A], ram[8'h7B], ram[8'h7C]}); end
  endtask

  task automatic test_err;
    int cyc, wec; logic [31:0] rd; logic e;
    issue(1'b0, 3'b010, 32'h81, 32'h0);
    wait_done(cyc, wec, rd, e);
    n_cmp++; if (cyc !== 1 || e !== 1'b1) begin n_fail++; $display("FAIL err_lw_mis: got cyc=%0d err=%b want 1/1", cyc, e); end
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL err_lw_rdata: got %h want 0", rd); end
    poke(8'h90, 8'hC3);
    issue(1'b1, 3'b100, 32'h90, 32'hFFFFFF11);
    wait_done(cyc, wec, rd, e);
    n_cmp++; if (cyc !== 1 || e !== 1'b1 || wec !== 0) begin n_fail++; $display("FAIL err_sbu: got cyc=%0d err=%b we=%0d want 1/1/0", cyc, e, wec); end
    n_cmp++; if (ram[8'h90] !== 8'hC3) begin n_fail++; $display("FAIL err_sbu_ram: got %h want c3", ram[8'h90]); end
    issue(1'b0, 3'b011, 32'h80, 32'h0);
    wait_done(cyc, wec, rd, e);
    n_cmp++; if (cyc !== 1 || e !== 1'b1) begin n_fail++; $display("FAIL err_width3: got cyc=%0d err=%b want 1/1", cyc, e); end
  endtask

  task automatic test_reset_mid;
    int dn;
    poke(8'h40, 8'hAA); poke(8'h41, 8'hAA); poke(8'h42, 8'hAA); poke(8'h43, 8'hAA);
    issue(1'b1, 3'b010, 32'h40, 32'h11223344);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rmid_we_before: got %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we_drop: got %b want 0", mem_we); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    n_cmp++; if (dn !== 0) begin n_fail++; $display("FAIL rmid_done: got %0d pulses want 0", dn); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    n_cmp++; if ({ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]} !== 32'h4433AAAA) begin n_fail++; $display("FAIL rmid_ram: got %h want 4433aaaa", {ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]}); end
  endtask

  task automatic test_back_to_back;
    int dn;
    logic exp_busy;
    poke(8'h80, 8'h58); poke(8'h81, 8'h00); poke(8'h82, 8'h00); poke(8'h83, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_width = 3'b010; req_addr = 32'h80; req_wdata = 32'h0;
    dn = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_busy = (k >= 1 && k <= 5) || (k >= 7 && k <= 11);
      n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy%0d: got %b want %b", k, busy, exp_busy); end
      if (k == 6) begin
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
      end
      if (done) begin
        dn++;
        n_cmp++; if (rdata !== 32'h58) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h want 00000058", k, rdata); end
      end
      if (k == 11) req_valid = 1'b0;
    end
    n_cmp++; if (dn !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", dn); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_width = 3'b000; req_addr = '0; req_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    test_reset();
    test_lw();
    test_lb_lbu_lh();
    test_sh();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
